// File: rtl/router_pkg.sv
// Shared packet-format constants, commit status codes and the CRC placement rule
// for the router packet queue.
package router_pkg;

    localparam int SRC_IDX   = 0;
    localparam int DST_IDX   = 1;
    localparam int SIZE_IDX  = 2;
    localparam int HDR_BYTES = 3;

    typedef enum logic [1:0] {
        WERR_OK   = 2'b00,
        WERR_FULL = 2'b01,
        WERR_LEN  = 2'b10
    } werr_e;

    // The CRC byte immediately follows the payload: byte index size + 3.
    function automatic logic [15:0] crc_offset(input logic [15:0] size);
        return size + 16'(HDR_BYTES);
    endfunction

endpackage

// File: rtl/router_pkt_mem.sv
// Packet byte storage: CHANNELS x DEPTH slots of WIDTH bytes, one write port,
// one registered read port and an unregistered peek at the tail slot's size byte.
module router_pkt_mem
    import router_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CH_SZ     = 2,
    parameter int DEPTH     = 4,
    parameter int PTR_SZ    = 2,
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [CH_SZ-1:0]     i_wch,
    input  logic [PTR_SZ-1:0]    i_wslot,
    input  logic [PTR_IN_SZ-1:0] i_waddr,
    input  logic [UWIDTH-1:0]    i_wdata,
    input  logic                 i_rvalid,
    input  logic [CH_SZ-1:0]     i_rch,
    input  logic [PTR_SZ-1:0]    i_rslot,
    input  logic [PTR_IN_SZ-1:0] i_raddr,
    output logic [UWIDTH-1:0]    o_rdata,
    output logic [UWIDTH-1:0]    o_tail_size
);

    logic [UWIDTH-1:0] r_mem [CHANNELS][DEPTH][WIDTH];

    // Byte array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wch][i_wslot][i_waddr] <= i_wdata;
        end
    end

    // Registered read; sampling the array before this edge's write gives read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata <= {UWIDTH{1'b0}};
        end else if (i_rvalid) begin
            o_rdata <= r_mem[i_rch][i_rslot][i_raddr];
        end else begin
            o_rdata <= {UWIDTH{1'b0}};
        end
    end

    assign o_tail_size = r_mem[i_wch][i_wslot][SIZE_IDX];

endmodule

// File: rtl/router_pkt_queue.sv
// Multi-channel packet queue: per-channel wrap-bit pointers, atomic commit with
// length validation, atomic pop, error pulses and occupancy readout.
module router_pkt_queue
    import router_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CH_SZ     = 2,
    parameter int DEPTH     = 4,
    parameter int PTR_SZ    = 2,
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wen,
    input  logic [CH_SZ-1:0]     wch,
    input  logic [PTR_IN_SZ-1:0] waddr_in,
    input  logic [UWIDTH-1:0]    wdata,
    input  logic                 winc,
    input  logic [CH_SZ-1:0]     rch,
    input  logic [PTR_IN_SZ-1:0] raddr_in,
    input  logic                 rinc,
    output logic [UWIDTH-1:0]    rdata,
    output logic [CHANNELS-1:0]  wfull,
    output logic [CHANNELS-1:0]  rempty,
    output logic [1:0]           werr,
    output logic                 rerr,
    output logic [PTR_SZ:0]      rcount
);

    localparam logic [PTR_IN_SZ:0] L_WIDTH    = (PTR_IN_SZ+1)'(WIDTH);
    localparam logic [15:0]        L_MAX_SIZE = 16'(WIDTH - HDR_BYTES - 1);
    localparam logic [PTR_IN_SZ-1:0] L_SIZE_IDX = PTR_IN_SZ'(SIZE_IDX);

    logic [PTR_SZ:0]       r_wptr [CHANNELS];
    logic [PTR_SZ:0]       r_rptr [CHANNELS];
    logic [PTR_SZ:0]       w_wptr_nxt [CHANNELS];
    logic [PTR_SZ:0]       w_rptr_nxt [CHANNELS];
    logic [CHANNELS-1:0]   w_full;
    logic [CHANNELS-1:0]   w_empty;
    logic [CHANNELS-1:0]   w_full_nxt;
    logic [CHANNELS-1:0]   w_empty_nxt;
    logic [PTR_SZ:0]       w_rcount_nxt;
    werr_e                 w_werr_nxt;
    logic                  w_rerr_nxt;
    logic [UWIDTH-1:0]     w_tail_size;
    logic [UWIDTH-1:0]     w_size_eff;
    logic                  w_len_bad;
    logic                  w_we;
    logic                  w_rvalid;

    // Current-state full/empty flags from the wrap-bit pointers.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_full[c]  = (r_wptr[c] == {~r_rptr[c][PTR_SZ], r_rptr[c][PTR_SZ-1:0]});
            w_empty[c] = (r_wptr[c] == r_rptr[c]);
        end
    end

    assign w_we     = !rst && wen && !w_full[wch] && ({1'b0, waddr_in} < L_WIDTH);
    assign w_rvalid = ({1'b0, raddr_in} < L_WIDTH);

    // A size byte written in the commit cycle takes precedence over the stored one.
    assign w_size_eff = (wen && (waddr_in == L_SIZE_IDX)) ? wdata : w_tail_size;
    assign w_len_bad  = (16'(w_size_eff) > L_MAX_SIZE) ||
                        (16'(waddr_in) != crc_offset(16'(w_size_eff)));

    // Commit/pop decisions, all judged on pre-cycle flags.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_wptr_nxt[c] = r_wptr[c];
            w_rptr_nxt[c] = r_rptr[c];
        end
        w_werr_nxt = WERR_OK;
        w_rerr_nxt = 1'b0;
        if (winc) begin
            if (w_full[wch]) begin
                w_werr_nxt = WERR_FULL;
            end else if (w_len_bad) begin
                w_werr_nxt = WERR_LEN;
            end else begin
                w_wptr_nxt[wch] = r_wptr[wch] + (PTR_SZ+1)'(1);
            end
        end else begin
            w_werr_nxt = WERR_OK;
        end
        if (rinc) begin
            if (w_empty[rch]) begin
                w_rerr_nxt = 1'b1;
            end else begin
                w_rptr_nxt[rch] = r_rptr[rch] + (PTR_SZ+1)'(1);
            end
        end else begin
            w_rerr_nxt = 1'b0;
        end
    end

    // Flags and occupancy as they will stand after this edge.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_full_nxt[c]  = (w_wptr_nxt[c] ==
                              {~w_rptr_nxt[c][PTR_SZ], w_rptr_nxt[c][PTR_SZ-1:0]});
            w_empty_nxt[c] = (w_wptr_nxt[c] == w_rptr_nxt[c]);
        end
        w_rcount_nxt = w_wptr_nxt[rch] - w_rptr_nxt[rch];
    end

    // Pointer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
            end
            wfull  <= {CHANNELS{1'b0}};
            rempty <= {CHANNELS{1'b1}};
            werr   <= 2'b00;
            rerr   <= 1'b0;
            rcount <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_wptr[c] <= w_wptr_nxt[c];
                r_rptr[c] <= w_rptr_nxt[c];
            end
            wfull  <= w_full_nxt;
            rempty <= w_empty_nxt;
            werr   <= w_werr_nxt;
            rerr   <= w_rerr_nxt;
            rcount <= w_rcount_nxt;
        end
    end

    router_pkt_mem #(
        .CHANNELS (CHANNELS),
        .CH_SZ    (CH_SZ),
        .DEPTH    (DEPTH),
        .PTR_SZ   (PTR_SZ),
        .WIDTH    (WIDTH),
        .UWIDTH   (UWIDTH),
        .PTR_IN_SZ(PTR_IN_SZ)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we),
        .i_wch      (wch),
        .i_wslot    (r_wptr[wch][PTR_SZ-1:0]),
        .i_waddr    (waddr_in),
        .i_wdata    (wdata),
        .i_rvalid   (w_rvalid),
        .i_rch      (rch),
        .i_rslot    (r_rptr[rch][PTR_SZ-1:0]),
        .i_raddr    (raddr_in),
        .o_rdata    (rdata),
        .o_tail_size(w_tail_size)
    );

endmodule

// File: tb/tb_router_pkt_queue.sv
// Directed bench for router_pkt_queue with a per-channel packet model and
// scoreboard queues for commit status and read data.
module tb_router_pkt_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, wen, winc, rinc;
    logic [1:0]  wch, rch;
    logic [3:0]  waddr_in, raddr_in;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [3:0]  wfull, rempty;
    logic [1:0]  werr;
    logic        rerr;
    logic [2:0]  rcount;

    int total = 0;
    int bad   = 0;

    logic [87:0] mq [4][$];
    logic [7:0]  sb_rd [$];
    logic [1:0]  sb_werr [$];

    always #5 clk = ~clk;

    router_pkt_queue dut (
        .clk(clk), .rst(rst), .wen(wen), .wch(wch), .waddr_in(waddr_in),
        .wdata(wdata), .winc(winc), .rch(rch), .raddr_in(raddr_in), .rinc(rinc),
        .rdata(rdata), .wfull(wfull), .rempty(rempty), .werr(werr), .rerr(rerr),
        .rcount(rcount)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [87:0] mk(input logic [7:0] src, input logic [7:0] dst,
                                       input logic [7:0] sz, input logic [7:0] base);
        logic [87:0] p;
        p = '0;
        p[7:0]   = src;
        p[15:8]  = dst;
        p[23:16] = sz;
        for (int i = 0; i < 7; i++) begin
            if (i < int'(sz)) p[8*(3+i) +: 8] = base + 8'(i);
        end
        if (sz <= 8'd7) p[8*(3+int'(sz)) +: 8] = src ^ dst ^ 8'hA5;
        return p;
    endfunction

    task automatic write_byte(input logic [1:0] ch, input int idx, input logic [7:0] d);
        wen = 1'b1; wch = ch; waddr_in = 4'(idx); wdata = d;
        step();
        wen = 1'b0;
    endtask

    // Final byte plus commit; expected status derived from the model before it changes.
    task automatic commit_last(input logic [1:0] ch, input logic [87:0] p, input int n,
                               input bit with_pop);
        logic [7:0] sz;
        logic [1:0] ew;
        sz = p[23:16];
        if (mq[ch].size() == DEPTH) ew = 2'b01;
        else if (sz > 8'd7 || (n - 1) != int'(sz) + 3) ew = 2'b10;
        else ew = 2'b00;
        sb_werr.push_back(ew);
        if (with_pop && mq[ch].size() != 0) void'(mq[ch].pop_front());
        if (ew == 2'b00) mq[ch].push_back(p);
        wen = 1'b1; wch = ch; waddr_in = 4'(n - 1); wdata = p[8*(n-1) +: 8];
        winc = 1'b1; rch = ch; rinc = with_pop;
        step();
        wen = 1'b0; winc = 1'b0; rinc = 1'b0;
        chk("werr", 32'(werr), 32'(sb_werr.pop_front()));
        chk("rcount", 32'(rcount), 32'(mq[ch].size()));
        chk("rempty", 32'(rempty[ch]), 32'(mq[ch].size() == 0));
        chk("wfull", 32'(wfull[ch]), 32'(mq[ch].size() == DEPTH));
        if (with_pop) chk("rerr_pop", 32'(rerr), 32'd0);
    endtask

    task automatic send_pkt(input logic [1:0] ch, input logic [87:0] p, input int n,
                            input bit with_pop);
        for (int i = 0; i < n - 1; i++) write_byte(ch, i, p[8*i +: 8]);
        commit_last(ch, p, n, with_pop);
    endtask

    task automatic read_pkt(input logic [1:0] ch, input bit do_pop);
        logic [87:0] p;
        int n;
        if (mq[ch].size() == 0) begin
            chk("model_nonempty", 32'd0, 32'd1);
            return;
        end
        p = mq[ch][0];
        n = int'(p[23:16]) + 4;
        for (int i = 0; i < n; i++) begin
            rch = ch; raddr_in = 4'(i);
            sb_rd.push_back(p[8*i +: 8]);
            step();
            chk("rdata", 32'(rdata), 32'(sb_rd.pop_front()));
        end
        if (do_pop) begin
            rch = ch; rinc = 1'b1;
            step();
            rinc = 1'b0;
            void'(mq[ch].pop_front());
            chk("rerr_ok", 32'(rerr), 32'd0);
            chk("rcount_pop", 32'(rcount), 32'(mq[ch].size()));
            chk("rempty_pop", 32'(rempty[ch]), 32'(mq[ch].size() == 0));
        end
    endtask

    initial begin
        logic [87:0] pa, pb;
        rst = 1'b1; wen = 1'b0; winc = 1'b0; rinc = 1'b0;
        wch = 2'd0; rch = 2'd0; waddr_in = 4'd0; raddr_in = 4'd0; wdata = 8'd0;
        step(); step();
        rst = 1'b0;
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_wfull", 32'(wfull), 32'd0);
        chk("rst_rempty", 32'(rempty), 32'hF);
        chk("rst_werr", 32'(werr), 32'd0);
        chk("rst_rerr", 32'(rerr), 32'd0);
        chk("rst_rcount", 32'(rcount), 32'd0);

        // Reference packet 10,160,3,0,1,2,15 on ch0, read back then popped.
        send_pkt(2'd0, {32'd0, 8'd15, 8'd2, 8'd1, 8'd0, 8'd3, 8'd160, 8'd10}, 7, 1'b0);
        step();
        chk("werr_pulse", 32'(werr), 32'd0);
        read_pkt(2'd0, 1'b1);

        // Fill ch2, overflow, pop, refill, then drain in order.
        send_pkt(2'd2, mk(8'd100, 8'd1, 8'd2, 8'h10), 6, 1'b0);
        send_pkt(2'd2, mk(8'd255, 8'd2, 8'd0, 8'h20), 4, 1'b0);
        send_pkt(2'd2, mk(8'd63, 8'd3, 8'd7, 8'h30), 11, 1'b0);
        send_pkt(2'd2, mk(8'd7, 8'd4, 8'd1, 8'h40), 5, 1'b0);
        send_pkt(2'd2, mk(8'd200, 8'd5, 8'd3, 8'h50), 7, 1'b0);
        rch = 2'd2; raddr_in = 4'd12;
        step();
        chk("rdata_oob", 32'(rdata), 32'd0);
        raddr_in = 4'd0;
        step();
        chk("head_src", 32'(rdata), 32'd100);
        read_pkt(2'd2, 1'b1);
        send_pkt(2'd2, mk(8'd200, 8'd5, 8'd3, 8'h50), 7, 1'b0);
        for (int k = 0; k < DEPTH; k++) read_pkt(2'd2, 1'b1);

        // Length violations on ch1.
        send_pkt(2'd1, mk(8'd11, 8'd12, 8'd4, 8'h60), 7, 1'b0);
        send_pkt(2'd1, mk(8'd13, 8'd14, 8'd8, 8'h70), 11, 1'b0);

        // Pop on empty ch1.
        rch = 2'd1; rinc = 1'b1;
        step();
        rinc = 1'b0;
        chk("rerr_empty", 32'(rerr), 32'd1);
        chk("rcount_empty", 32'(rcount), 32'd0);
        step();
        chk("rerr_pulse", 32'(rerr), 32'd0);
        chk("rempty_ch1", 32'(rempty[1]), 32'd1);

        // Full ch3 with commit and pop in one cycle.
        for (int k = 0; k < DEPTH; k++)
            send_pkt(2'd3, mk(8'(k + 1), 8'd33, 8'(k), 8'(8'h80 + 8'(k * 16))), k + 4, 1'b0);
        send_pkt(2'd3, mk(8'd99, 8'd33, 8'd2, 8'hC0), 6, 1'b1);

        // Byte-interleaved packets on ch0 and ch1.
        pa = mk(8'd21, 8'd22, 8'd5, 8'hD0);
        pb = mk(8'd31, 8'd32, 8'd5, 8'hE0);
        for (int i = 0; i < 8; i++) begin
            write_byte(2'd0, i, pa[8*i +: 8]);
            write_byte(2'd1, i, pb[8*i +: 8]);
        end
        commit_last(2'd0, pa, 9, 1'b0);
        commit_last(2'd1, pb, 9, 1'b0);
        read_pkt(2'd1, 1'b1);
        read_pkt(2'd0, 1'b1);
        read_pkt(2'd3, 1'b1);

        // Reset mid-packet with strobes present in the reset cycle.
        write_byte(2'd0, 0, 8'd77);
        write_byte(2'd0, 1, 8'd78);
        rst = 1'b1; wen = 1'b1; winc = 1'b1; rinc = 1'b1; rch = 2'd3;
        wch = 2'd0; waddr_in = 4'd2; wdata = 8'd0;
        step();
        rst = 1'b0; wen = 1'b0; winc = 1'b0; rinc = 1'b0;
        for (int c = 0; c < 4; c++) mq[c].delete();
        chk("mrst_rempty", 32'(rempty), 32'hF);
        chk("mrst_wfull", 32'(wfull), 32'd0);
        chk("mrst_rcount", 32'(rcount), 32'd0);
        chk("mrst_werr", 32'(werr), 32'd0);
        chk("mrst_rerr", 32'(rerr), 32'd0);
        step();
        chk("mrst_rcount2", 32'(rcount), 32'd0);
        send_pkt(2'd3, mk(8'd44, 8'd45, 8'd3, 8'hF0), 7, 1'b0);
        read_pkt(2'd3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
